// File: rtl/register_file_pkg.sv
// Shared MIPS definitions: ABI register indices and instruction field slices.
package register_file_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int INST_W     = 32;

  // ABI register names, numbered in hardware index order.
  typedef enum logic [REG_ADDR_W-1:0] {
    zero, at, v0, v1, a0, a1, a2, a3,
    t0, t1, t2, t3, t4, t5, t6, t7,
    s0, s1, s2, s3, s4, s5, s6, s7,
    t8, t9, k0, k1, gp, sp, fp, ra
  } abi_reg_t;

  // Instruction field positions.
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

  function automatic logic [REG_ADDR_W-1:0] inst_rs(input logic [INST_W-1:0] inst);
    return inst[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [REG_ADDR_W-1:0] inst_rt(input logic [INST_W-1:0] inst);
    return inst[RT_MSB:RT_LSB];
  endfunction

  function automatic logic [REG_ADDR_W-1:0] inst_rd(input logic [INST_W-1:0] inst);
    return inst[RD_MSB:RD_LSB];
  endfunction

endpackage

// File: rtl/register_file.sv
// MIPS register file: two combinational read ports, one write port committed
// on the falling clock edge, $zero hardwired, $v0/$a0 tapped for syscalls.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  localparam int ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic [ADDR_W-1:0]     readRegister1,
  input  logic [ADDR_W-1:0]     readRegister2,
  input  logic [ADDR_W-1:0]     writeRegister,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  regWrite,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  output logic [DATA_WIDTH-1:0] v0,
  output logic [DATA_WIDTH-1:0] a0
);

  import register_file_pkg::*;

  // Port names v0/a0 shadow the package constants, so the tap indices are scoped.
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(zero);
  localparam logic [ADDR_W-1:0] V0_IDX   = ADDR_W'(register_file_pkg::v0);
  localparam logic [ADDR_W-1:0] A0_IDX   = ADDR_W'(register_file_pkg::a0);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  wr_en;

  // An unknown regWrite falls to the no-write branch; address 0 is never stored.
  always_comb begin
    wr_en = 1'b0;
    if (regWrite && (writeRegister != ZERO_IDX)) begin
      wr_en = 1'b1;
    end
  end

  // Falling-edge write; reset clears every register and blocks writes while held.
  always_ff @(negedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < unsigned'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[writeRegister] <= writeData;
    end
  end

  // Combinational read ports with $zero masked; no write bypass.
  always_comb begin
    readData1 = '0;
    readData2 = '0;
    if (readRegister1 != ZERO_IDX) begin
      readData1 = regs[readRegister1];
    end
    if (readRegister2 != ZERO_IDX) begin
      readData2 = regs[readRegister2];
    end
  end

  // Continuous syscall taps.
  always_comb begin
    v0 = regs[V0_IDX];
    a0 = regs[A0_IDX];
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: an array model of the architectural
// registers is compared against every port twice per clock, plus literal checks.
module tb_register_file;

  logic        clock;
  logic        resetN;
  logic [4:0]  readRegister1;
  logic [4:0]  readRegister2;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic        regWrite;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] tap_v0;
  logic [31:0] tap_a0;

  int n_cmp = 0;
  int n_bad = 0;

  // Architectural state as seen by software.
  logic [31:0] model [32];

  register_file #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
    .clock         (clock),
    .resetN        (resetN),
    .readRegister1 (readRegister1),
    .readRegister2 (readRegister2),
    .writeRegister (writeRegister),
    .writeData     (writeData),
    .regWrite      (regWrite),
    .readData1     (readData1),
    .readData2     (readData2),
    .v0            (tap_v0),
    .a0            (tap_a0)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  // Register semantics: reset wipes everything; a committed write lands at the falling edge.
  always @(negedge clock or negedge resetN) begin
    if (resetN !== 1'b1) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (regWrite === 1'b1 && writeRegister != 5'd0) begin
      model[writeRegister] = writeData;
    end
  end

  // Check all outputs mid-phase after each edge (after posedge: pre-write, after negedge: post-write).
  always @(posedge clock or negedge clock) begin
    #6;
    chk("rd1", readData1, model_read(readRegister1));
    chk("rd2", readData2, model_read(readRegister2));
    chk("v0",  tap_v0,    model[2]);
    chk("a0",  tap_a0,    model[4]);
  end

  task automatic cyc(input logic [4:0] rr1, input logic [4:0] rr2, input logic [4:0] wr,
                     input logic [31:0] wd, input logic we);
    @(posedge clock);
    #3;
    readRegister1 = rr1;
    readRegister2 = rr2;
    writeRegister = wr;
    writeData     = wd;
    regWrite      = we;
    @(negedge clock);
    #1;
  endtask

  initial begin
    resetN        = 1'b0;
    readRegister1 = 5'd0;
    readRegister2 = 5'd0;
    writeRegister = 5'd7;
    writeData     = 32'hFFFF_FFFF;
    regWrite      = 1'b1;

    // Test 1: reset, with a write attempt held off while reset is low.
    @(negedge clock);
    #1;
    chk("rst_v0", tap_v0, 32'h0);
    @(negedge clock);
    #4;
    resetN   = 1'b1;
    regWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      cyc(5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b0);
      chk("rst_rd1", readData1, 32'h0);
      chk("rst_rd2", readData2, 32'h0);
    end
    chk("rst_a0", tap_a0, 32'h0);

    // Test 2: write and read back on both ports.
    cyc(5'd8, 5'd0, 5'd8, 32'hDEAD_BEEF, 1'b1);
    chk("wr8_rd1", readData1, 32'hDEAD_BEEF);
    cyc(5'd8, 5'd8, 5'd0, 32'h0, 1'b0);
    chk("wr8_rd2", readData2, 32'hDEAD_BEEF);

    // Test 3: syscall taps without any read address applied.
    cyc(5'd0, 5'd0, 5'd2, 32'h0000_0001, 1'b1);
    chk("tap_v0", tap_v0, 32'h0000_0001);
    cyc(5'd0, 5'd0, 5'd4, 32'h0000_002A, 1'b1);
    chk("tap_a0", tap_a0, 32'd42);
    chk("tap_v0_hold", tap_v0, 32'h0000_0001);

    // Test 4: $zero is immutable; disabled write leaves reg 9 alone.
    cyc(5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1);
    chk("zero_rd1", readData1, 32'h0);
    cyc(5'd0, 5'd9, 5'd9, 32'h1234_5678, 1'b0);
    chk("nowe_rd2", readData2, 32'h0);

    // Test 5: no bypass - old value until the falling edge, new value after.
    cyc(5'd5, 5'd5, 5'd5, 32'h0000_0011, 1'b1);
    chk("r5_init", readData1, 32'h0000_0011);
    @(posedge clock);
    #3;
    writeRegister = 5'd5;
    writeData     = 32'h0000_0055;
    regWrite      = 1'b1;
    #2;
    chk("r5_pre", readData1, 32'h0000_0011);
    @(negedge clock);
    #1;
    chk("r5_post", readData1, 32'h0000_0055);
    chk("r5_post_rd2", readData2, 32'h0000_0055);

    // Test 6: reset between edges clears state at once and cancels the pending write.
    cyc(5'd3, 5'd8, 5'd3, 32'hA5A5_A5A5, 1'b1);
    chk("r3_fill", readData1, 32'hA5A5_A5A5);
    @(posedge clock);
    #3;
    writeRegister = 5'd3;
    writeData     = 32'h0BAD_F00D;
    regWrite      = 1'b1;
    #5;
    resetN = 1'b0;
    #1;
    chk("mid_rst_r3", readData1, 32'h0);
    chk("mid_rst_r8", readData2, 32'h0);
    chk("mid_rst_v0", tap_v0, 32'h0);
    chk("mid_rst_a0", tap_a0, 32'h0);
    @(negedge clock);
    #4;
    resetN   = 1'b1;
    regWrite = 1'b0;
    #1;
    chk("cancel_r3", readData1, 32'h0);
    cyc(5'd3, 5'd5, 5'd0, 32'h0, 1'b0);
    chk("after_r3", readData1, 32'h0);
    chk("after_r5", readData2, 32'h0);

    // Model sanity after reset: a fresh write lands normally.
    cyc(5'd3, 5'd0, 5'd3, 32'hCAFE_0003, 1'b1);
    chk("post_rst_wr", readData1, 32'hCAFE_0003);

    @(posedge clock);
    #8;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
